// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one timer/main_counter pair between N_REQ requesters.
//
// Each requester holds a level request with a period on its req_period slice.
// The arbiter grants one owner at a time, round-robin from ptr, latches the
// owner's period into period_reg, lets it settle for one LOAD cycle, then
// enables the timer and counter until irq_flag arrives. A one-cycle DONE state
// pulses done[owner] and irq_clr. If the owner drops its request, the
// transaction is abandoned without a done pulse.
//
// Optional feature: define TIMER_ARB_WATCHDOG_EN to add a RUN-state watchdog
// that gives up after period_reg+TO_MARGIN+1 cycles and pulses to_err.
//
// Ports:
//   chosen_clk  clock, everything on posedge
//   rst         synchronous active-high reset
//   req         per-requester level request
//   req_period  flat period bus, slice i = [i*PW +: PW]
//   irq_flag    timer interrupt flag
//   grant       one-hot current owner, 0 when idle
//   done        one-cycle completion pulse to the owner
//   period_reg  latched period driven to timer and main_counter
//   counter_en  main_counter enable
//   timer_en    timer enable
//   timer_mode  fixed 0 (one-shot)
//   irq_clr     one-cycle irq_flag clear strobe
//   to_err      one-cycle watchdog timeout pulse (0 without the watchdog)
module timer_arbiter #(
    parameter int N_REQ     = 4,
    parameter int PW        = 16,
    parameter int TO_MARGIN = 4
) (
    input  logic                  chosen_clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*PW-1:0]   req_period,
    input  logic                  irq_flag,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic [PW-1:0]         period_reg,
    output logic                  counter_en,
    output logic                  timer_en,
    output logic                  timer_mode,
    output logic                  irq_clr,
    output logic                  to_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] owner_nxt;
    logic [PW-1:0]    pick_period;
    logic             pick_vld;

    // Round-robin pick: scan offsets from the far end down so the smallest
    // offset from ptr is the last (winning) assignment.
    always_comb begin
        int idx;
        idx         = 0;
        pick        = '0;
        pick_period = '0;
        pick_vld    = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                pick        = PTR_W'(idx);
                pick_period = req_period[idx*PW +: PW];
                pick_vld    = 1'b1;
            end
        end
    end

    assign owner_nxt  = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
    assign timer_mode = 1'b0;

`ifdef TIMER_ARB_WATCHDOG_EN
    logic [PW:0] wdog;
    logic [PW:0] wd_limit;
    // One extra bit so period_reg + margin cannot wrap.
    assign wd_limit = {1'b0, period_reg} + (PW+1)'(TO_MARGIN) + (PW+1)'(1);
`else
    assign to_err = 1'b0;
`endif

    always_ff @(posedge chosen_clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            grant      <= '0;
            done       <= '0;
            period_reg <= '0;
            counter_en <= 1'b0;
            timer_en   <= 1'b0;
            irq_clr    <= 1'b0;
`ifdef TIMER_ARB_WATCHDOG_EN
            to_err     <= 1'b0;
            wdog       <= '0;
`endif
        end else begin
            // Pulses default low; only transitions into DONE raise them.
            done    <= '0;
            irq_clr <= 1'b0;
`ifdef TIMER_ARB_WATCHDOG_EN
            to_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant      <= N_REQ'(1) << pick;
                        owner      <= pick;
                        period_reg <= pick_period;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (!req[owner]) begin
                        irq_clr <= 1'b1;
                        state   <= DONE;
                    end else if (period_reg == '0) begin
                        // Nothing to count: complete without touching the timer.
                        done    <= grant;
                        irq_clr <= 1'b1;
                        state   <= DONE;
                    end else begin
                        counter_en <= 1'b1;
                        timer_en   <= 1'b1;
`ifdef TIMER_ARB_WATCHDOG_EN
                        wdog       <= '0;
`endif
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (!req[owner]) begin
                        counter_en <= 1'b0;
                        timer_en   <= 1'b0;
                        irq_clr    <= 1'b1;
                        state      <= DONE;
                    end else if (irq_flag) begin
                        counter_en <= 1'b0;
                        timer_en   <= 1'b0;
                        done       <= grant;
                        irq_clr    <= 1'b1;
                        state      <= DONE;
                    end
`ifdef TIMER_ARB_WATCHDOG_EN
                    else if ((wdog + 1'b1) == wd_limit) begin
                        counter_en <= 1'b0;
                        timer_en   <= 1'b0;
                        irq_clr    <= 1'b1;
                        to_err     <= 1'b1;
                        state      <= DONE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end
                DONE: begin
                    grant <= '0;
                    ptr   <= owner_nxt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Testbench for timer_arbiter: directed scenarios plus randomized contention.
// The reference is transaction level: the winner is the first pending
// requester at or after the last owner + 1, the timer is modelled as counting
// enabled cycles up to the granted period, and each transaction is checked
// for grant latency, latched period, enabled-cycle count and completion pulses.
module tb_timer_arbiter;

    localparam int N   = 4;
    localparam int PW  = 16;
    localparam int TOM = 4;

    logic            chosen_clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*PW-1:0] req_period;
    logic            irq_flag;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [PW-1:0]   period_reg;
    logic            counter_en;
    logic            timer_en;
    logic            timer_mode;
    logic            irq_clr;
    logic            to_err;

    int            checks = 0;
    int            errors = 0;
    int            ptr_m  = 0;
    logic [PW-1:0] per [N];

    timer_arbiter #(.N_REQ(N), .PW(PW), .TO_MARGIN(TOM)) dut (
        .chosen_clk (chosen_clk),
        .rst        (rst),
        .req        (req),
        .req_period (req_period),
        .irq_flag   (irq_flag),
        .grant      (grant),
        .done       (done),
        .period_reg (period_reg),
        .counter_en (counter_en),
        .timer_en   (timer_en),
        .timer_mode (timer_mode),
        .irq_clr    (irq_clr),
        .to_err     (to_err)
    );

    always #5 chosen_clk = ~chosen_clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Observe and drive at negedge, well away from the active edge.
    task automatic step();
        @(negedge chosen_clk);
    endtask

    task automatic drive_periods();
        for (int i = 0; i < N; i++) req_period[i*PW +: PW] = per[i];
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // One transaction from IDLE. abort_after>0 drops the owner's request after
    // that many enabled cycles; no_irq withholds the timer interrupt.
    task automatic serve(input int abort_after, input bit scramble, input bit no_irq);
        int            w;
        int            lat;
        int            en;
        int            exp_en;
        bit            fin;
        logic [PW-1:0] pl;
        logic [N-1:0]  exp_done;
        w   = rr_pick(req, ptr_m);
        pl  = per[w];
        lat = 0;
        do begin step(); lat++; end while (grant == '0 && lat < 4);
        chk("grant_lat", lat, 1);
        chk("grant", grant, N'(1) << w);
        chk("period_reg", period_reg, pl);
        chk("load_en", {counter_en, timer_en}, 2'b00);
        en  = 0;
        fin = 0;
        for (int c = 0; c < int'(pl) + TOM + 12; c++) begin
            if (scramble) begin
                for (int i = 0; i < N; i++) per[i] = PW'($urandom_range(0, 7));
                drive_periods();
                if ($urandom_range(0, 3) == 0) req = req | (N'($urandom) & ~(N'(1) << w));
            end
            step();
            if (done != '0 || irq_clr) begin fin = 1; break; end
            chk("run_en", {counter_en, timer_en}, 2'b11);
            chk("run_period_hold", period_reg, pl);
            en++;
            if (!no_irq && en == int'(pl)) irq_flag = 1'b1;
            if (abort_after > 0 && en == abort_after) req[w] = 1'b0;
        end
        chk("done_seen", fin, 1'b1);
        if (no_irq)               exp_en = int'(pl) + TOM + 1;
        else if (abort_after > 0) exp_en = abort_after;
        else                      exp_en = int'(pl);
        exp_done = (no_irq || abort_after > 0) ? '0 : N'(1) << w;
        chk("en_cycles", en, exp_en);
        chk("done", done, exp_done);
        chk("irq_clr", irq_clr, 1'b1);
        chk("done_en_off", {counter_en, timer_en}, 2'b00);
        chk("to_err", to_err, no_irq);
        irq_flag = 1'b0;
        req[w]   = 1'b0;
        ptr_m    = (w + 1) % N;
        step();
        chk("idle_grant", grant, '0);
        chk("idle_pulses", {done, irq_clr, to_err}, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ptr_m = 0;
    endtask

    initial begin
        int nserve;
        rst      = 1'b1;
        req      = '0;
        irq_flag = 1'b0;
        for (int i = 0; i < N; i++) per[i] = '0;
        drive_periods();
        step();
        do_reset();
        chk("rst_grant", grant, '0);
        chk("rst_done", done, '0);
        chk("rst_period", period_reg, '0);
        chk("rst_en", {counter_en, timer_en, timer_mode}, 3'b000);
        chk("rst_pulses", {irq_clr, to_err}, 2'b00);

        // Single request, period 4.
        per[0] = 16'd4; drive_periods();
        req = 4'b0001;
        serve(0, 0, 0);

        // Contention from reset: order 0,1,2,3 then 0,2.
        do_reset();
        per[0] = 1; per[1] = 2; per[2] = 3; per[3] = 4; drive_periods();
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            chk("order", rr_pick(req, ptr_m), i);
            serve(0, 0, 0);
        end
        req = 4'b0101;
        serve(0, 0, 0);
        chk("order_re", rr_pick(req, ptr_m), 2);
        serve(0, 0, 0);

        // Zero period: LOAD straight to DONE, timer never enabled.
        per[2] = 0; drive_periods();
        req = 4'b0100;
        serve(0, 0, 0);

        // Abort at RUN cycle 3, then ptr must point at requester 2.
        per[1] = 10; drive_periods();
        req = 4'b0010;
        serve(3, 0, 0);
        chk("abort_ptr", ptr_m, 2);
        per[2] = 2; drive_periods();
        req = 4'b1111;
        serve(0, 0, 0);
        req = '0;

        // Reset in the middle of RUN.
        do_reset();
        per[3] = 6; drive_periods();
        req = 4'b1000;
        step(); step(); step();
        chk("mid_run_en", {counter_en, timer_en}, 2'b11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = '0;
        ptr_m = 0;
        chk("mid_rst_en", {counter_en, timer_en}, 2'b00);
        chk("mid_rst_pulses", {done, irq_clr, to_err}, '0);
        chk("mid_rst_grant", grant, '0);
        step();

`ifdef TIMER_ARB_WATCHDOG_EN
        per[3] = 3; drive_periods();
        req = 4'b1000;
        serve(0, 0, 1);
`endif

        // Randomized contention with mid-transaction noise and aborts.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++) per[i] = PW'($urandom_range(0, 7));
            drive_periods();
            req = N'($urandom_range(1, (1 << N) - 1));
            nserve = 0;
            while (req != '0 && nserve < 20) begin
                int w;
                int ab;
                w  = rr_pick(req, ptr_m);
                ab = 0;
                if (per[w] > 1 && $urandom_range(0, 3) == 0)
                    ab = $urandom_range(1, int'(per[w]) - 1);
                serve(ab, 1, 0);
                nserve++;
            end
            req = '0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
